// File: rtl/xps2_rx_periph_pkg.sv
// Shared definitions for the PS/2 receive peripheral: register map,
// STATUS/CTRL bit positions, receiver FSM states and a count helper.
package xps2_rx_periph_pkg;

    // Register offsets on the bus
    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;

    // STATUS bit positions (count occupies [3:0])
    localparam int ST_EMPTY = 4;
    localparam int ST_FULL  = 5;
    localparam int ST_OVF   = 6;
    localparam int ST_PERR  = 7;
    localparam int ST_FERR  = 8;
    localparam int ST_BUSY  = 9;

    // CTRL bit positions
    localparam int CTRL_EN    = 0;
    localparam int CTRL_IEN   = 1;
    localparam int CTRL_FLUSH = 2;

    // Frame receiver states
    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_e;

    // Fit the FIFO occupancy into the 4-bit STATUS field, saturating at 15
    function automatic logic [3:0] sat_count4(input logic [31:0] count);
        return (count > 32'd15) ? 4'hF : count[3:0];
    endfunction

endpackage

// File: rtl/xps2_rx_periph_frame_rx.sv
// PS/2 frame receiver: synchronises the raw pins, deglitches the PS/2 clock,
// turns its falling edges into bit strobes and assembles 11-bit frames.
// Emits one-cycle pulses for a good byte, a parity error or a framing error.
module xps2_frame_rx
    import xps2_rx_periph_pkg::*;
#(
    parameter int FILTER_LEN = 4,
    parameter int TIMEOUT    = 5000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       byte_vld,
    output logic       perr,
    output logic       ferr,
    output logic       busy
);

    localparam int FILT_W = $clog2(FILTER_LEN + 1);
    localparam int TMO_W  = $clog2(TIMEOUT + 1);
    localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(FILTER_LEN - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT - 1);

    logic [1:0]        clk_sync;
    logic [1:0]        data_sync;
    logic              clk_filt;
    logic [FILT_W-1:0] filt_cnt;
    logic              strobe;
    rx_state_e         state;
    logic [2:0]        bit_cnt;
    logic [7:0]        shreg;
    logic              perr_pending;
    logic [TMO_W-1:0]  tmo_cnt;

    // Two-flop synchronisers on both pins; the bus idles high
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
        end
    end

    // Accept a clock level only after FILTER_LEN consecutive differing samples;
    // a 1->0 acceptance is the bit strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_filt <= 1'b1;
            filt_cnt <= '0;
            strobe   <= 1'b0;
        end else begin
            strobe <= 1'b0;
            if (clk_sync[1] == clk_filt) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FILT_LAST) begin
                clk_filt <= clk_sync[1];
                filt_cnt <= '0;
                strobe   <= clk_filt;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    // Frame FSM with idle timeout; disabling the receiver drops any partial frame silently
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            state        <= RX_IDLE;
            bit_cnt      <= '0;
            shreg        <= '0;
            perr_pending <= 1'b0;
            tmo_cnt      <= '0;
            rx_byte      <= '0;
            byte_vld     <= 1'b0;
            perr         <= 1'b0;
            ferr         <= 1'b0;
        end else begin
            byte_vld <= 1'b0;
            perr     <= 1'b0;
            ferr     <= 1'b0;

            if (state == RX_IDLE || strobe) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end

            if (state != RX_IDLE && !strobe && tmo_cnt == TMO_LAST) begin
                state <= RX_IDLE;
                ferr  <= 1'b1;
            end else if (strobe) begin
                case (state)
                    RX_IDLE: begin
                        if (!data_sync[1]) begin
                            state        <= RX_DATA;
                            bit_cnt      <= '0;
                            perr_pending <= 1'b0;
                        end
                    end
                    RX_DATA: begin
                        shreg   <= {data_sync[1], shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= RX_PARITY;
                        end
                    end
                    RX_PARITY: begin
                        perr_pending <= ~(^{shreg, data_sync[1]});
                        state        <= RX_STOP;
                    end
                    RX_STOP: begin
                        if (data_sync[1] && !perr_pending) begin
                            rx_byte  <= shreg;
                            byte_vld <= 1'b1;
                        end else if (data_sync[1]) begin
                            perr <= 1'b1;
                        end else begin
                            ferr <= 1'b1;
                        end
                        perr_pending <= 1'b0;
                        state        <= RX_IDLE;
                    end
                    default: state <= RX_IDLE;
                endcase
            end
        end
    end

    assign busy = (state != RX_IDLE);

endmodule

// File: rtl/xps2_rx_periph.sv
// PS/2 keyboard receive peripheral: frame receiver, scancode FIFO and the
// DATA/STATUS/CTRL register block on the zero-wait read/write bus.
module xps2_rx_periph
    import xps2_rx_periph_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int FILTER_LEN = 4,
    parameter int TIMEOUT    = 5000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sel,
    input  logic              rw_req,
    input  logic              rw_rnw,
    input  logic [1:0]        rw_addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    input  logic              ps2_clk,
    input  logic              ps2_data,
    output logic              irq
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [7:0]        mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              en;
    logic              ien;
    logic              overflow;
    logic              parity_err;
    logic              frame_err;

    logic [7:0]        rx_byte;
    logic              byte_vld;
    logic              perr;
    logic              ferr;
    logic              busy;

    logic              empty;
    logic              full;
    logic              rd_access;
    logic              wr_access;
    logic              pop;
    logic              push;
    logic              ctrl_wr;
    logic              flush;
    logic [DATA_W-1:0] status;
    logic              unused_data_in;

    xps2_frame_rx #(
        .FILTER_LEN (FILTER_LEN),
        .TIMEOUT    (TIMEOUT)
    ) u_frame_rx (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .rx_byte  (rx_byte),
        .byte_vld (byte_vld),
        .perr     (perr),
        .ferr     (ferr),
        .busy     (busy)
    );

    assign empty     = (count == '0);
    assign full      = (count == CNT_W'(FIFO_DEPTH));
    assign rd_access = sel & rw_req & rw_rnw;
    assign wr_access = sel & rw_req & ~rw_rnw;
    assign pop       = rd_access && (rw_addr == REG_DATA) && !empty;
    assign ctrl_wr   = wr_access && (rw_addr == REG_CTRL);
    assign flush     = ctrl_wr && data_in[CTRL_FLUSH];
    // A pop in the same cycle frees the slot a full FIFO needs for the push
    assign push      = byte_vld && (!full || pop);
    assign irq       = ien & ~empty;
    assign unused_data_in = ^data_in[DATA_W-1:3];

    // Scancode storage
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; count and pointers say which
        // entries are valid, so stale contents are never observed.
        if (push && !flush) begin
            mem[wr_ptr] <= rx_byte;
        end
    end

    // FIFO bookkeeping, sticky error flags and CTRL register
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            en         <= 1'b1;
            ien        <= 1'b0;
            overflow   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                en  <= data_in[CTRL_EN];
                ien <= data_in[CTRL_IEN];
            end
            if (flush) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                count      <= '0;
                overflow   <= 1'b0;
                parity_err <= 1'b0;
                frame_err  <= 1'b0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
                if (byte_vld && full && !pop) overflow <= 1'b1;
                if (perr) parity_err <= 1'b1;
                if (ferr) frame_err  <= 1'b1;
            end
        end
    end

    // Read mux: zero unless a read of this peripheral is in progress
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        status             = '0;
        status[3:0]        = sat_count4(32'(count));
        status[ST_EMPTY]   = empty;
        status[ST_FULL]    = full;
        status[ST_OVF]     = overflow;
        status[ST_PERR]    = parity_err;
        status[ST_FERR]    = frame_err;
        status[ST_BUSY]    = busy;

        data_out = '0;
        if (rd_access) begin
            case (rw_addr)
                REG_DATA:   if (!empty) data_out[7:0] = mem[rd_ptr];
                REG_STATUS: data_out = status;
                REG_CTRL:   data_out[1:0] = {ien, en};
                default:    data_out = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_xps2_rx_periph.sv
// Self-checking bench for xps2_rx_periph: drives PS/2 frames and bus accesses,
// keeps a queue-based model of the FIFO and flags, and compares every cycle.
module tb_xps2_rx_periph;

    localparam int DATA_W     = 32;
    localparam int DEPTH      = 8;
    localparam int FILTER_LEN = 4;
    localparam int TIMEOUT    = 5000;
    localparam int HALF       = 12;

    logic              clk      = 1'b0;
    logic              rst      = 1'b1;
    logic              sel      = 1'b0;
    logic              rw_req   = 1'b0;
    logic              rw_rnw   = 1'b0;
    logic [1:0]        rw_addr  = 2'd0;
    logic [DATA_W-1:0] data_in  = '0;
    logic [DATA_W-1:0] data_out;
    logic              ps2_clk  = 1'b1;
    logic              ps2_data = 1'b1;
    logic              irq;

    always #5 clk = ~clk;

    xps2_rx_periph #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (DEPTH),
        .FILTER_LEN (FILTER_LEN),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sel      (sel),
        .rw_req   (rw_req),
        .rw_rnw   (rw_rnw),
        .rw_addr  (rw_addr),
        .data_in  (data_in),
        .data_out (data_out),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .irq      (irq)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model
    logic [7:0] m_q[$];
    bit m_en, m_ien, m_ovf, m_perr, m_ferr, m_busy;
    bit in_frame = 1'b0;

    logic [7:0] codes [9] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43};

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [1:0] a);
        logic [31:0] r;
        r = '0;
        case (a)
            2'd0: if (m_q.size() != 0) r[7:0] = m_q[0];
            2'd1: begin
                r[3:0] = 4'(m_q.size());
                r[4]   = (m_q.size() == 0);
                r[5]   = (m_q.size() == DEPTH);
                r[6]   = m_ovf;
                r[7]   = m_perr;
                r[8]   = m_ferr;
                r[9]   = m_busy;
            end
            2'd2: r[1:0] = {m_ien, m_en};
            default: r = '0;
        endcase
        return r;
    endfunction

    // Compare process: checks irq and data_out every cycle and applies bus side effects to the model
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                m_q.delete();
                m_en = 1'b1; m_ien = 1'b0;
                m_ovf = 1'b0; m_perr = 1'b0; m_ferr = 1'b0; m_busy = 1'b0;
            end else begin
                if (!in_frame)
                    check("irq", {31'b0, irq}, {31'b0, (m_ien && (m_q.size() != 0))});
                if (sel && rw_req && rw_rnw) begin
                    check($sformatf("read_addr%0d", rw_addr), data_out, model_read(rw_addr));
                    if (rw_addr == 2'd0 && m_q.size() != 0) void'(m_q.pop_front());
                end else begin
                    check("idle_data_out", data_out, 32'h0);
                    if (sel && rw_req && rw_addr == 2'd2) begin
                        m_en  = data_in[0];
                        m_ien = data_in[1];
                        if (data_in[2]) begin
                            m_q.delete();
                            m_ovf = 1'b0; m_perr = 1'b0; m_ferr = 1'b0;
                        end
                    end
                end
            end
        end
    end

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        @(posedge clk); #1;
        sel = 1'b1; rw_req = 1'b1; rw_rnw = 1'b1; rw_addr = a;
        @(negedge clk);
        d = data_out;
        @(posedge clk); #1;
        sel = 1'b0; rw_req = 1'b0; rw_rnw = 1'b0;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        sel = 1'b1; rw_req = 1'b1; rw_rnw = 1'b0; rw_addr = a; data_in = d;
        @(posedge clk); #1;
        sel = 1'b0; rw_req = 1'b0; data_in = '0;
    endtask

    // kind: 0 good, 1 bad parity, 2 bad stop. nbits < 11 sends a truncated frame.
    // read_at > 0 issues a DATA read during that cycle of the stop bit's low phase.
    task automatic send_frame(input logic [7:0] b, input int kind, input int nbits, input int read_at);
        logic [10:0] bits;
        bits = {(kind != 2), (~^b) ^ (kind == 1), b, 1'b0};
        in_frame = 1'b1;
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            repeat (HALF) @(posedge clk);
            #1 ps2_clk = 1'b0;
            for (int k = 1; k <= HALF; k++) begin
                @(posedge clk); #1;
                if (i == 10 && k == read_at) begin
                    sel = 1'b1; rw_req = 1'b1; rw_rnw = 1'b1; rw_addr = 2'd0;
                end
                if (i == 10 && read_at > 0 && k == read_at + 1) begin
                    sel = 1'b0; rw_req = 1'b0; rw_rnw = 1'b0;
                end
            end
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (HALF) @(posedge clk);
        #1;
        if (nbits == 11 && m_en) begin
            if (kind == 2)                  m_ferr = 1'b1;
            else if (kind == 1)             m_perr = 1'b1;
            else if (m_q.size() == DEPTH)   m_ovf  = 1'b1;
            else                            m_q.push_back(b);
        end
        in_frame = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        bus_read(2'd1, rd); check("reset_status", rd, 32'h010);
        bus_read(2'd2, rd); check("reset_ctrl", rd, 32'h001);
        bus_read(2'd0, rd); check("reset_data", rd, 32'h000);
        check("reset_irq", {31'b0, irq}, 32'h0);

        // 1: good frame 0x1C
        send_frame(8'h1C, 0, 11, 0);
        bus_read(2'd1, rd); check("t1_status", rd, 32'h001);
        bus_read(2'd0, rd); check("t1_data", rd, 32'h01C);
        bus_read(2'd1, rd); check("t1_empty", rd, 32'h010);

        // 2: bad parity, then flush with en+ien
        send_frame(8'h5A, 1, 11, 0);
        bus_read(2'd1, rd); check("t2_perr", rd, 32'h090);
        bus_write(2'd2, 32'h7);
        bus_read(2'd1, rd); check("t2_flushed", rd, 32'h010);
        bus_read(2'd2, rd); check("t2_ctrl", rd, 32'h003);

        // 3: nine frames, no reads
        for (int i = 0; i < 9; i++) send_frame(codes[i], 0, 11, 0);
        bus_read(2'd1, rd); check("t3_full_ovf", rd, 32'h068);
        check("t3_irq", {31'b0, irq}, 32'h1);
        for (int i = 0; i < 8; i++) begin
            bus_read(2'd0, rd); check($sformatf("t3_pop%0d", i), rd, {24'h0, codes[i]});
        end
        bus_read(2'd1, rd); check("t3_drained", rd, 32'h050);
        bus_write(2'd2, 32'h7);

        // 4: read on the cycle the ninth byte is pushed into a full FIFO
        for (int i = 0; i < 8; i++) send_frame(codes[i], 0, 11, 0);
        send_frame(codes[8], 0, 11, 7);
        bus_read(2'd1, rd); check("t4_status", rd, 32'h028);
        for (int i = 1; i < 9; i++) begin
            bus_read(2'd0, rd); check($sformatf("t4_pop%0d", i), rd, {24'h0, codes[i]});
        end

        // 5: stalled frame times out
        send_frame(8'hAA, 0, 5, 0);
        m_busy = 1'b1;
        bus_read(2'd1, rd); check("t5_busy", rd, 32'h210);
        repeat (TIMEOUT + 1) @(posedge clk);
        #1;
        m_busy = 1'b0;
        m_ferr = 1'b1;
        bus_read(2'd1, rd); check("t5_ferr", rd, 32'h110);
        send_frame(8'h29, 0, 11, 0);
        bus_read(2'd0, rd); check("t5_next", rd, 32'h029);
        bus_write(2'd2, 32'h7);

        // Receiver disabled: frame ignored
        bus_write(2'd2, 32'h0);
        send_frame(8'h77, 0, 11, 0);
        bus_read(2'd1, rd); check("dis_status", rd, 32'h010);
        bus_write(2'd2, 32'h3);

        // 6: reset mid-frame
        send_frame(8'h33, 0, 4, 0);
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        bus_read(2'd0, rd); check("t6_data", rd, 32'h000);
        bus_read(2'd1, rd); check("t6_status", rd, 32'h010);
        bus_read(2'd2, rd); check("t6_ctrl", rd, 32'h001);
        send_frame(8'h45, 0, 11, 0);
        bus_read(2'd0, rd); check("t6_next", rd, 32'h045);

        // Randomised frames, reads and writes against the model
        for (int n = 0; n < 30; n++) begin
            int r;
            int kind;
            int nrd;
            logic [31:0] w;
            r    = $urandom_range(0, 99);
            kind = (r < 10) ? 1 : ((r < 20) ? 2 : 0);
            send_frame(8'($urandom), kind, 11, 0);
            nrd = $urandom_range(0, 3);
            for (int j = 0; j < nrd; j++) bus_read(2'($urandom_range(0, 3)), rd);
            if ($urandom_range(0, 99) < 25) begin
                w    = $urandom;
                w[0] = ($urandom_range(0, 3) != 0);
                w[2] = ($urandom_range(0, 4) == 0);
                bus_write(2'($urandom_range(0, 3)), w);
            end
        end
        for (int j = 0; j < DEPTH + 1; j++) bus_read(2'd0, rd);
        bus_read(2'd1, rd);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
